// File: rtl/fetch_rf_arb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_rf_arb_ctrl_pkg
//  Purpose  : Shared constants for the fetch reference RF arbiter: pixel
//             width, RF geometry, starvation limit and arbiter state
//             encodings.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_rf_arb_ctrl_pkg;

  localparam int PIXEL_WIDTH        = 8;
  localparam int FETCH_RF_DEPTH     = 48;
  localparam int FETCH_RF_ADDR_W    = 6;
  localparam int FETCH_RF_DATA_W    = 48 * PIXEL_WIDTH;
  localparam int FETCH_RF_MAX_WAIT  = 4;
  localparam int FETCH_RF_CNT_W     = 7;

  // Arbiter priority state
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_WR_PRI = 1'b0;
  localparam arb_state_t ST_RD_PRI = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_rf_scoreboard
//  Purpose  : Per-row valid bits for the fetch reference RF plus a running
//             count of valid rows.
//  Ports    : clk, rst         clock / async active-high reset
//             i_clear          invalidate every row (wins over i_set)
//             i_set/i_set_addr mark a row valid at the clock edge
//             i_look_addr      row to look up
//             o_look_hit       looked-up row is valid (registered state only)
//             o_valid_cnt      number of valid rows
//  Revision : 1.0  initial release
// ============================================================================
module fetch_rf_scoreboard
  import fetch_rf_arb_ctrl_pkg::*;
#(
  parameter int DEPTH  = FETCH_RF_DEPTH,
  parameter int ADDR_W = FETCH_RF_ADDR_W,
  parameter int CNT_W  = FETCH_RF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic [ADDR_W-1:0] i_look_addr,
  output logic              o_look_hit,
  output logic [CNT_W-1:0]  o_valid_cnt
);

  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_set_in;
  logic             w_look_in;

  assign w_set_in  = i_set && ({1'b0, i_set_addr} < c_depth_ext);
  assign w_look_in = {1'b0, i_look_addr} < c_depth_ext;

  // Lookup sees only registered bits, so a row written this cycle is not
  // visible to a read until the next cycle.
  assign o_look_hit  = w_look_in && r_valid[i_look_addr];
  assign o_valid_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (w_set_in) begin
      r_valid[i_set_addr] <= 1'b1;
      if (!r_valid[i_set_addr]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_rf_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_rf_arb_ctrl
//  Purpose  : Shares the single port of the fetch reference RF between the
//             DDR write path and the search-window read path. Reads are only
//             granted to written rows; a starvation guard forces a pending
//             eligible read ahead after MAX_WAIT consecutive write grants.
//  Ports    : clk, rst                     clock / async active-high reset
//             clear_i                      invalidate all rows (new CTU)
//             wr_req_i/addr/data, wr_ack_o write requester
//             rd_req_i/addr, rd_ack_o      read requester
//             rd_valid_o, rd_data_o        read return, one cycle after ack
//             err_o                        out-of-range access pulse
//             valid_cnt_o                  number of valid rows
//             mem_en_o/addr/wdata, mem_rdata_i   RF port
//  Revision : 1.0  initial release
// ============================================================================
module fetch_rf_arb_ctrl
  import fetch_rf_arb_ctrl_pkg::*;
#(
  parameter int DEPTH    = FETCH_RF_DEPTH,
  parameter int ADDR_W   = FETCH_RF_ADDR_W,
  parameter int DATA_W   = FETCH_RF_DATA_W,
  parameter int MAX_WAIT = FETCH_RF_MAX_WAIT,
  parameter int CNT_W    = FETCH_RF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_ack_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  valid_cnt_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int              WAIT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W+1)'(DEPTH);
  localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;

  logic              w_wr_oor;
  logic              w_rd_oor;
  logic              w_rd_hit;
  logic              w_rd_elig;
  logic              w_wr_gnt;
  logic              w_rd_gnt;

  logic [ADDR_W-1:0] r_last_addr;
  logic              r_rd_pend;
  logic              r_rd_oor;

  assign w_wr_oor  = {1'b0, wr_addr_i} >= c_depth_ext;
  assign w_rd_oor  = {1'b0, rd_addr_i} >= c_depth_ext;
  // Out-of-range reads never touch the RF, so they need no valid bit.
  assign w_rd_elig = rd_req_i && (w_rd_oor || w_rd_hit);

  fetch_rf_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (clear_i),
    .i_set       (w_wr_gnt),
    .i_set_addr  (wr_addr_i),
    .i_look_addr (rd_addr_i),
    .o_look_hit  (w_rd_hit),
    .o_valid_cnt (valid_cnt_o)
  );

  // --------------------------------------------------------------------------
  // Arbiter FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WR_PRI;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (!w_rd_elig || w_rd_gnt) begin
      // Nothing left to protect: drop back to write priority.
      w_state_nxt = ST_WR_PRI;
      w_wait_nxt  = '0;
    end else if ((r_state == ST_WR_PRI) && w_wr_gnt) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
      if (w_wait_nxt >= c_max_wait) begin
        w_state_nxt = ST_RD_PRI;
      end
    end
    // An eligible read left ungranted without a write grant (clear cycle)
    // keeps the current state and count.
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM: grant outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_gnt = 1'b0;
    w_rd_gnt = 1'b0;
    if (!clear_i) begin
      case (r_state)
        ST_RD_PRI: begin
          if (w_rd_elig)     w_rd_gnt = 1'b1;
          else if (wr_req_i) w_wr_gnt = 1'b1;
        end
        default: begin
          if (wr_req_i)       w_wr_gnt = 1'b1;
          else if (w_rd_elig) w_rd_gnt = 1'b1;
        end
      endcase
    end
  end

  assign wr_ack_o = w_wr_gnt;
  assign rd_ack_o = w_rd_gnt;
  assign err_o    = (w_wr_gnt && w_wr_oor) || (w_rd_gnt && w_rd_oor);

  // --------------------------------------------------------------------------
  // RF port mux; the address holds its last value when the port is idle
  // --------------------------------------------------------------------------
  assign mem_en_o    = w_wr_gnt && !w_wr_oor;
  assign mem_wdata_o = wr_data_i;

  always_comb begin
    mem_addr_o = r_last_addr;
    if (w_wr_gnt && !w_wr_oor) begin
      mem_addr_o = wr_addr_i;
    end else if (w_rd_gnt && !w_rd_oor) begin
      mem_addr_o = rd_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_addr <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_last_addr <= mem_addr_o;
      r_rd_pend   <= w_rd_gnt;
      r_rd_oor    <= w_rd_gnt && w_rd_oor;
    end
  end

  // RF data is already registered inside the RF, so it is passed straight
  // through; out-of-range reads return zero.
  assign rd_valid_o = r_rd_pend;
  assign rd_data_o  = r_rd_oor ? '0 : mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_fetch_rf_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_rf_arb_ctrl
//  Purpose  : Scoreboard bench for fetch_rf_arb_ctrl. The driver pushes the
//             expected acks / read returns into queues; a monitor pops and
//             compares whenever the DUT presents one.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_rf_arb_ctrl;

  localparam int DW = 384;
  localparam int AW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_i;
  logic          wr_req_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ack_o;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_ack_o;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          err_o;
  logic [CW-1:0] valid_cnt_o;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  fetch_rf_arb_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .wr_req_i    (wr_req_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_ack_o    (wr_ack_o),
    .rd_req_i    (rd_req_i),
    .rd_addr_i   (rd_addr_i),
    .rd_ack_o    (rd_ack_o),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .err_o       (err_o),
    .valid_cnt_o (valid_cnt_o),
    .mem_en_o    (mem_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RF model with one-cycle registered read
  logic [DW-1:0] rf_mem [0:63];
  always @(posedge clk) begin
    if (mem_en_o) rf_mem[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= rf_mem[mem_addr_o];
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t q_wr[$];
  exp_t q_rd[$];
  exp_t q_rv[$];
  exp_t mon_e;
  logic [DW-1:0] exp_mem [0:47];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.cyc = cyc; x.addr = a; x.data = d; x.err = e;
    q_wr.push_back(x);
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic e);
    exp_t x;
    x.cyc = cyc; x.addr = a; x.data = '0; x.err = e;
    q_rd.push_back(x);
  endtask

  task automatic push_rv(input int at, input logic [DW-1:0] d);
    exp_t x;
    x.cyc = at; x.addr = '0; x.data = d; x.err = 1'b0;
    q_rv.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req_i  = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    if (a < 48) exp_mem[a] = d;
    push_wr(a, d, (a >= 48));
  endtask

  // ------------------------------------------------------------------------
  // Monitor
  // ------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_ack_o && rd_ack_o) chk("dual_ack", 1, 0);
      if (wr_ack_o) begin
        if (q_wr.size() == 0) begin
          chk("wr_ack_unexpected", 1, 0);
        end else begin
          mon_e = q_wr.pop_front();
          chk("wr_ack_cycle", cyc, mon_e.cyc);
          chk("wr_err", err_o, mon_e.err);
          chk("wr_mem_en", mem_en_o, !mon_e.err);
          if (!mon_e.err) begin
            chk("wr_mem_addr", mem_addr_o, mon_e.addr);
            chk("wr_mem_wdata", mem_wdata_o, mon_e.data);
          end
        end
      end
      if (rd_ack_o) begin
        if (q_rd.size() == 0) begin
          chk("rd_ack_unexpected", 1, 0);
        end else begin
          mon_e = q_rd.pop_front();
          chk("rd_ack_cycle", cyc, mon_e.cyc);
          chk("rd_err", err_o, mon_e.err);
          chk("rd_mem_en", mem_en_o, 0);
          if (!mon_e.err) chk("rd_mem_addr", mem_addr_o, mon_e.addr);
        end
      end
      if (!wr_ack_o && !rd_ack_o) chk("idle_en_err", {mem_en_o, err_o}, 0);
      if (rd_valid_o) begin
        if (q_rv.size() == 0) begin
          chk("rd_valid_unexpected", 1, 0);
        end else begin
          mon_e = q_rv.pop_front();
          chk("rd_valid_cycle", cyc, mon_e.cyc);
          chk("rd_data", rd_data_o, mon_e.data);
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Driver
  // ------------------------------------------------------------------------
  initial begin
    rst = 1'b1; clear_i = 1'b0;
    wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    rd_req_i = 1'b0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {wr_ack_o, rd_ack_o, rd_valid_o, err_o, mem_en_o}, 0);
    chk("reset_valid_cnt", valid_cnt_o, 0);
    rst = 1'b0;
    tick();

    // 1: fill all rows, one write per cycle
    for (int i = 0; i < 48; i++) begin
      do_write(AW'(i), {48{8'(i)}});
      tick();
    end
    wr_req_i = 1'b0;
    chk("fill_valid_cnt", valid_cnt_o, 48);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear_valid_cnt", valid_cnt_o, 0);

    // 2: read of an unwritten row waits for the write, then one more cycle
    rd_req_i = 1'b1; rd_addr_i = 6'd5;
    tick();
    tick();
    do_write(6'd5, {48{8'h55}});
    tick();
    wr_req_i = 1'b0;
    push_rd(6'd5, 1'b0);
    push_rv(cyc + 1, {48{8'h55}});
    tick();
    rd_req_i = 1'b0;
    tick();

    // 3: starvation guard, four write grants then the read
    do_write(6'd3, {48{8'h33}});
    tick();
    rd_req_i = 1'b1; rd_addr_i = 6'd3;
    for (int k = 0; k < 4; k++) begin
      do_write(AW'(10 + k), {48{8'(10 + k)}});
      tick();
    end
    wr_req_i = 1'b1; wr_addr_i = 6'd14; wr_data_i = {48{8'd14}};
    push_rd(6'd3, 1'b0);
    push_rv(cyc + 1, {48{8'h33}});
    tick();
    rd_req_i = 1'b0;
    do_write(6'd14, {48{8'd14}});
    tick();
    do_write(6'd15, {48{8'd15}});
    tick();
    wr_req_i = 1'b0;
    chk("starve_valid_cnt", valid_cnt_o, 8);

    // 4: read granted, then clear with a write in the next cycle
    rd_req_i = 1'b1; rd_addr_i = 6'd15;
    push_rd(6'd15, 1'b0);
    push_rv(cyc + 1, {48{8'd15}});
    tick();
    rd_req_i = 1'b0;
    clear_i = 1'b1;
    wr_req_i = 1'b1; wr_addr_i = 6'd7; wr_data_i = {48{8'h77}};
    tick();
    clear_i = 1'b0; wr_req_i = 1'b0;
    chk("clear_wr_valid_cnt", valid_cnt_o, 0);
    rd_req_i = 1'b1; rd_addr_i = 6'd7;
    repeat (3) tick();
    rd_req_i = 1'b0;
    tick();

    // 5: out-of-range accesses
    do_write(6'd50, {48{8'hEE}});
    tick();
    wr_req_i = 1'b0;
    rd_req_i = 1'b1; rd_addr_i = 6'd63;
    push_rd(6'd63, 1'b1);
    push_rv(cyc + 1, '0);
    tick();
    rd_req_i = 1'b0;
    tick();
    chk("oor_valid_cnt", valid_cnt_o, 0);

    // 6: reset right after a read grant discards the read return
    do_write(6'd20, {48{8'h20}});
    tick();
    wr_req_i = 1'b0;
    rd_req_i = 1'b1; rd_addr_i = 6'd20;
    push_rd(6'd20, 1'b0);
    tick();
    rd_req_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_rd_valid", rd_valid_o, 0);
    chk("rst_mid_valid_cnt", valid_cnt_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_after_outputs", {wr_ack_o, rd_ack_o, rd_valid_o, err_o, mem_en_o}, 0);
    rd_req_i = 1'b1; rd_addr_i = 6'd20;
    repeat (2) tick();
    rd_req_i = 1'b0;
    tick();
    tick();

    chk("left_wr_exp", q_wr.size(), 0);
    chk("left_rd_exp", q_rd.size(), 0);
    chk("left_rv_exp", q_rv.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_rf_arb_ctrl.md
Name: fetch_rf_arb_ctrl

Overview:
Arbitration and hazard controller in front of the single-port 48-row x 48-pixel fetch reference RF. It shares the one RF port between a write requester (DDR load path) and a read requester (motion-estimation search-window fetch). It keeps a per-row valid scoreboard so that no unwritten row is ever read, and a starvation guard so that reads still progress under sustained write traffic.

Parameters:
DEPTH, 48, number of RF rows
ADDR_W, 6, row address width
DATA_W, 384, row width in bits (48*`PIXEL_WIDTH)
MAX_WAIT, 4, number of consecutive write grants a pending eligible read tolerates before it is forced ahead
CNT_W, 7, width of valid_cnt_o

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
clear_i  in  1  single-cycle pulse; invalidates all rows at a new CTU
wr_req_i  in  1  write request
wr_addr_i  in  ADDR_W  write row
wr_data_i  in  DATA_W  write data
wr_ack_o  out  1  write granted this cycle
rd_req_i  in  1  read request
rd_addr_i  in  ADDR_W  read row
rd_ack_o  out  1  read granted this cycle
rd_valid_o  out  1  read data valid
rd_data_o  out  DATA_W  read data
err_o  out  1  out-of-range access pulse
valid_cnt_o  out  CNT_W  number of valid rows
mem_en_o  out  1  RF write enable (1 = write cycle)
mem_addr_o  out  ADDR_W  RF address
mem_wdata_o  out  DATA_W  RF write data
mem_rdata_i  in  DATA_W  RF read data; registered in the RF, 1-cycle latency

Behaviour:
- Reset values: all acks, rd_valid_o, err_o and mem_en_o are 0; valid_cnt_o=0; scoreboard all 0; wait_cnt=0; FSM in WR_PRI.
- Handshake: req/addr/data are held stable until ack. An ack is combinational in the same cycle as the req. At most one ack per cycle.
- Read eligibility: rd_req_i && (rd_addr_i>=DEPTH || valid[rd_addr_i]).
- Same-cycle write/read hazard: a valid bit set by a write in cycle T makes the row eligible from T+1 onward, never in T.
- FSM WR_PRI:
  - a write request wins;
  - otherwise an eligible read is granted;
  - if a write is granted while an eligible read waits, wait_cnt increments;
  - when wait_cnt reaches MAX_WAIT, go to RD_PRI.
- FSM RD_PRI:
  - an eligible read wins;
  - on a read grant, clear wait_cnt and return to WR_PRI;
  - if the read is no longer eligible or is withdrawn, return to WR_PRI with wait_cnt=0.
- wait_cnt clears whenever no eligible read is pending.
- Write grant in cycle T:
  - mem_en_o=1, mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i;
  - sets valid[wr_addr_i] at the clock edge;
  - valid_cnt_o increments only if the row was previously invalid.
- Read grant in cycle T: mem_en_o=0 and mem_addr_o=rd_addr_i. In T+1, rd_valid_o=1 for one cycle and rd_data_o=mem_rdata_i (pass-through, no extra register).
- Idle cycle: mem_en_o=0; mem_addr_o holds its last value.
- Out of range (addr>=DEPTH):
  - a write is acked and dropped: mem_en_o=0, err_o=1 in T;
  - a read is acked with no RF access: rd_valid_o=1 in T+1 with rd_data_o=0, err_o=1 in T.
- clear_i in T:
  - no grants in T;
  - scoreboard and valid_cnt_o go to 0 at the edge, overriding any set;
  - a rd_valid_o already owed for a read granted in T-1 still fires in T.
- Async rst mid-operation: immediate return to reset values; a pending rd_valid_o is discarded.

Decomposition:
- Shared package (enc_defines.v): `PIXEL_WIDTH, the fetch RF depth/address constants, and arbiter state encodings WR_PRI/RD_PRI.
- One sub-module: fetch_rf_scoreboard, which holds the valid vector, set/clear logic, lookup and valid_cnt. The arbiter FSM and RF port mux stay in the top.

Test Plan:
1. Reset, then write rows 0..47 with data=row index replicated -> valid_cnt_o=48, one wr_ack_o per cycle, mem_en_o=1 every cycle.
2. Read row 5 before it is written, holding rd_req_i; write row 5 in cycle T -> rd_ack_o first at T+1; rd_valid_o at T+2 with the written data.
3. Continuous writes while an eligible read of row 3 is pending, MAX_WAIT=4 -> four wr_acks, then rd_ack on the 5th cycle, then writes resume.
4. clear_i coincident with a write to row 7 -> no ack in that cycle; valid_cnt_o=0 afterwards; a later read of row 7 is stalled.
5. Write addr 50 and read addr 63 -> both acked, err_o pulses; read returns rd_data_o=0 with rd_valid_o one cycle after ack; no mem_en_o.
6. Assert rst in the cycle after a read grant -> rd_valid_o stays 0; all state returns to reset values.
